// File: rtl/blink_pkg.sv
// Shared types and helpers for the LED blink scheduler.
package blink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } chan_state_e;

  localparam int DUR_W_DEF = 16;

  function automatic int tick_div_f(input int clk_freq, input int tick_hz);
    return clk_freq / tick_hz;
  endfunction

endpackage

// File: rtl/blink_channel.sv
// One LED channel: on/off phase FSM, tick counter and stored durations.
module blink_channel
  import blink_pkg::*;
#(
  parameter int DUR_W = DUR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             apply,
  input  logic             enable,
  input  logic [DUR_W-1:0] on_in,
  input  logic [DUR_W-1:0] off_in,
  output logic             led,
  output logic             active
);

  chan_state_e      state_q, state_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic [DUR_W-1:0] on_q, on_d;
  logic [DUR_W-1:0] off_q, off_d;
  logic             led_q, led_d;
  logic [DUR_W-1:0] cnt_inc;

  // Saturate so permanent ON/OFF channels never wrap.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + DUR_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    on_d    = on_q;
    off_d   = off_q;
    if (apply) begin
      on_d  = on_in;
      off_d = off_in;
      cnt_d = '0;
      if (enable && on_in != '0) begin
        state_d = ST_ON;
      end else if (enable && off_in != '0) begin
        state_d = ST_OFF;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (tick) begin
      case (state_q)
        ST_ON: begin
          if (off_q != '0 && cnt_q == on_q - DUR_W'(1)) begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_OFF: begin
          if (on_q != '0 && cnt_q == off_q - DUR_W'(1)) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: ;
      endcase
    end
    led_d = (state_d == ST_ON);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      on_q    <= '0;
      off_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      on_q    <= on_d;
      off_q   <= off_d;
      led_q   <= led_d;
    end
  end

  assign led    = led_q;
  assign active = (state_q != ST_IDLE);

endmodule

// File: rtl/blink_scheduler.sv
// Multi-channel LED blink controller: shared prescaler, config port, channels.
module blink_scheduler
  import blink_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int NUM_LEDS = 8,
  parameter int DUR_W    = DUR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_led,
  input  logic             cfg_enable,
  input  logic [DUR_W-1:0] cfg_on_ticks,
  input  logic [DUR_W-1:0] cfg_off_ticks,
  output logic             cfg_err,
  output logic [7:0]       leds,
  output logic [7:0]       chan_active
);

  localparam int TICK_DIV = tick_div_f(CLK_FREQ, TICK_HZ);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [3:0] NL = 4'(NUM_LEDS);

  if (TICK_DIV < 1) begin : g_bad_div
    $error("blink_scheduler: TICK_DIV must be >= 1");
  end
  if (NUM_LEDS < 1 || NUM_LEDS > 8) begin : g_bad_num
    $error("blink_scheduler: NUM_LEDS must be 1..8");
  end

  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;
  logic             accept;
  logic             apply_q, apply_d;
  logic             err_q, err_d;
  logic [2:0]       idx_q, idx_d;
  logic             en_q, en_d;
  logic [DUR_W-1:0] on_q, on_d;
  logic [DUR_W-1:0] off_q, off_d;

  assign tick      = (presc_q == PMAX);
  assign cfg_ready = ~rst & ~apply_q;
  assign accept    = cfg_valid & cfg_ready;
  assign cfg_err   = err_q;

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    apply_d = accept;
    err_d   = accept && ({1'b0, cfg_led} >= NL);
    idx_d   = idx_q;
    en_d    = en_q;
    on_d    = on_q;
    off_d   = off_q;
    if (accept) begin
      idx_d = cfg_led;
      en_d  = cfg_enable;
      on_d  = cfg_on_ticks;
      off_d = cfg_off_ticks;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      apply_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      on_q    <= '0;
      off_q   <= '0;
    end else begin
      presc_q <= presc_d;
      apply_q <= apply_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      on_q    <= on_d;
      off_q   <= off_d;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_ch
    if (i < NUM_LEDS) begin : g_on
      blink_channel #(
        .DUR_W(DUR_W)
      ) u_ch (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .apply  (apply_q && idx_q == 3'(i)),
        .enable (en_q),
        .on_in  (on_q),
        .off_in (off_q),
        .led    (leds[i]),
        .active (chan_active[i])
      );
    end else begin : g_off
      assign leds[i]        = 1'b0;
      assign chan_active[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_blink_scheduler.sv
// Directed self-checking bench for blink_scheduler (TICK_DIV=10, 4 LEDs).
module tb_blink_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_led = '0;
  logic        cfg_enable = 1'b0;
  logic [15:0] cfg_on_ticks = '0;
  logic [15:0] cfg_off_ticks = '0;
  logic        cfg_err;
  logic [7:0]  leds;
  logic [7:0]  chan_active;

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  blink_scheduler #(
    .CLK_FREQ(1000),
    .TICK_HZ (100),
    .NUM_LEDS(4),
    .DUR_W   (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_led      (cfg_led),
    .cfg_enable   (cfg_enable),
    .cfg_on_ticks (cfg_on_ticks),
    .cfg_off_ticks(cfg_off_ticks),
    .cfg_err      (cfg_err),
    .leds         (leds),
    .chan_active  (chan_active)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_rng(input string tag, input int obs,
                         input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] led, input logic en,
                      input int on, input int off);
    cfg_valid     = 1'b1;
    cfg_led       = led;
    cfg_enable    = en;
    cfg_on_ticks  = 16'(on);
    cfg_off_ticks = 16'(off);
    cyc();
    cfg_valid = 1'b0;
    cyc();
  endtask

  // Counts samples while leds[b] holds val; stops on first differing sample.
  task automatic run_len(input int b, input logic val, output int n);
    n = 0;
    while (leds[b] === val && n < 200) begin
      n++;
      cyc();
    end
  endtask

  initial begin
    int n;
    int acc;
    logic ok;
    logic [7:0] snap_l;
    logic [7:0] snap_a;

    repeat (3) cyc();
    chk("rst_leds", leds, 0);
    chk("rst_active", chan_active, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_err", cfg_err, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", cfg_ready, 1);

    send(3'd2, 1'b1, 3, 2);
    chk("basic_led2_on", leds[2], 1);
    chk("basic_active", chan_active, 8'h04);
    chk("basic_leds", leds, 8'h04);
    run_len(2, 1'b1, n);
    chk_rng("basic_first_on", n, 21, 30);
    for (int p = 0; p < 5; p++) begin
      run_len(2, 1'b0, n);
      chk("basic_off_len", n, 20);
      run_len(2, 1'b1, n);
      chk("basic_on_len", n, 30);
    end
    chk("basic_others_off", leds & 8'hFB, 0);

    send(3'd2, 1'b1, 1, 1);
    chk("restart_led2", leds[2], 1);
    run_len(2, 1'b1, n);
    chk_rng("restart_first_on", n, 1, 10);
    run_len(2, 1'b0, n);
    chk("restart_off", n, 10);
    run_len(2, 1'b1, n);
    chk("restart_on", n, 10);

    // Now just after a tick edge; next tick edge is 10 clocks later.
    repeat (8) cyc();
    send(3'd3, 1'b1, 2, 2);
    chk("coll_led3_on", leds[3], 1);
    run_len(3, 1'b1, n);
    chk("coll_on_len", n, 20);

    send(3'd0, 1'b1, 0, 5);
    chk("off_only_led", leds[0], 0);
    chk("off_only_active", chan_active[0], 1);
    send(3'd1, 1'b1, 4, 0);
    chk("on_only_led", leds[1], 1);
    ok = 1'b1;
    repeat (200) begin
      cyc();
      if (leds[1] !== 1'b1) ok = 1'b0;
    end
    chk("on_only_hold", ok, 1);
    chk("off_only_hold", leds[0], 0);
    send(3'd3, 1'b1, 0, 0);
    chk("zero_active3", chan_active[3], 0);
    chk("zero_led3", leds[3], 0);

    send(3'd2, 1'b0, 3, 2);
    chk("dis_led2", leds[2], 0);
    chk("dis_active2", chan_active[2], 0);

    snap_l = leds;
    snap_a = chan_active;
    chk("static_leds", snap_l, 8'h02);
    chk("static_active", snap_a, 8'h03);
    cfg_valid = 1'b1;
    cfg_led   = 3'd7;
    cfg_enable = 1'b1;
    cfg_on_ticks = 16'd1;
    cfg_off_ticks = 16'd1;
    cyc();
    cfg_valid = 1'b0;
    chk("bad_err_pulse", cfg_err, 1);
    cyc();
    chk("bad_err_clear", cfg_err, 0);
    chk("bad_leds", leds, snap_l);
    chk("bad_active", chan_active, snap_a);

    acc = 0;
    cfg_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cfg_led = 3'(4 + k);
      chk("hs_ready", cfg_ready, (k % 2 == 0) ? 1 : 0);
      if (cfg_valid && cfg_ready) acc++;
      cyc();
    end
    cfg_valid = 1'b0;
    chk("hs_accepts", acc, 2);
    chk("hs_leds", leds, snap_l);

    rst = 1'b1;
    cyc();
    chk("mid_rst_leds", leds, 0);
    chk("mid_rst_active", chan_active, 0);
    chk("mid_rst_ready", cfg_ready, 0);
    rst = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
